// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - RV32I memory stage with req/ack data port and M->W pipeline register
//
// Purpose: issues loads/stores from the M stage on a req/ack data-memory port,
// aligns and extends load data, raises m_busy_o while an access is in flight,
// and registers the result into the W stage.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   W_stall_i, W_bubble_i    W register hold / clear
//   M_*_i                    M-stage register outputs (opcode, funct, valE, val2, rd, pcs, instr, commit)
//   dmem_*                   req/ack data-memory port (ack and rdata valid in the same cycle)
//   m_busy_o                 stall request to the hazard controller
//   W_*_o                    W-stage register outputs
module memory_access_stage #(
  parameter logic [6:0] OP_LOAD  = 7'b0000011,
  parameter logic [6:0] OP_STORE = 7'b0100011
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        W_stall_i,
  input  logic        W_bubble_i,
  input  logic [6:0]  M_opcode_i,
  input  logic [9:0]  M_funct_i,
  input  logic [31:0] M_valE_i,
  input  logic [31:0] M_val2_i,
  input  logic [4:0]  M_rd_i,
  input  logic [31:0] M_default_pc_i,
  input  logic [31:0] M_pc_i,
  input  logic [31:0] M_pre_pc_i,
  input  logic [31:0] M_instr_i,
  input  logic        M_commit_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        m_busy_o,
  output logic [6:0]  W_opcode_o,
  output logic [9:0]  W_funct_o,
  output logic [31:0] W_valE_o,
  output logic [31:0] W_valM_o,
  output logic [4:0]  W_rd_o,
  output logic [31:0] W_default_pc_o,
  output logic [31:0] W_instr_o,
  output logic        W_commit_o,
  output logic [31:0] W_pc_o,
  output logic [31:0] W_pre_pc_o,
  output logic        W_mem_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_valm_q;

  logic [2:0]  f3;
  logic [1:0]  a;
  logic        is_load, is_store, is_mem, err, mem_op;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val, valm_nxt;

  assign f3       = M_funct_i[2:0];
  assign a        = M_valE_i[1:0];
  assign is_load  = M_commit_i && (M_opcode_i == OP_LOAD);
  assign is_store = M_commit_i && (M_opcode_i == OP_STORE);
  assign is_mem   = is_load || is_store;

  always_comb begin
    err = 1'b0;
    if (is_load && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) err = 1'b1;
    if (is_store && !(f3 inside {3'b000, 3'b001, 3'b010})) err = 1'b1;
    if (is_mem && f3[1:0] == 2'b01 && a[0]) err = 1'b1;
    if (is_mem && f3[1:0] == 2'b10 && a != 2'b00) err = 1'b1;
  end

  assign mem_op = is_mem && !err;

  // Request is suppressed during reset and in HOLD, where the access has already been acked.
  assign dmem_req_o  = rst_n_i && mem_op && (state_q != S_HOLD);
  assign m_busy_o    = dmem_req_o && !dmem_ack_i;
  assign dmem_we_o   = mem_op && is_store;
  assign dmem_addr_o = {M_valE_i[31:2], 2'b00};

  always_comb begin
    dmem_wstrb_o = 4'b0000;
    dmem_wdata_o = M_val2_i;
    case (f3[1:0])
      2'b00: begin
        dmem_wstrb_o = 4'b0001 << a;
        dmem_wdata_o = {4{M_val2_i[7:0]}};
      end
      2'b01: begin
        dmem_wstrb_o = 4'b0011 << a;
        dmem_wdata_o = {2{M_val2_i[15:0]}};
      end
      default: dmem_wstrb_o = 4'b1111;
    endcase
    if (!(mem_op && is_store)) dmem_wstrb_o = 4'b0000;
  end

  always_comb begin
    case (a)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = a[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_val = {24'd0, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_val = {16'd0, ld_half};
      default: load_val = dmem_rdata_i;
    endcase
  end

  // In HOLD the read data is gone from the bus; W takes the value latched at ack.
  always_comb begin
    valm_nxt = 32'd0;
    if (state_q == S_HOLD) valm_nxt = hold_valm_q;
    else if (mem_op && is_load) valm_nxt = load_val;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (!mem_op) state_d = S_IDLE;
        else if (!dmem_ack_i) state_d = S_WAIT;
        else if (!W_bubble_i && W_stall_i) state_d = S_HOLD;
        else state_d = S_IDLE;
      end
      S_HOLD: begin
        if (W_bubble_i || !W_stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      hold_valm_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q != S_HOLD && state_d == S_HOLD) hold_valm_q <= valm_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i || (rst_n_i && (W_bubble_i || (!W_stall_i && m_busy_o)))) begin
      W_opcode_o     <= '0;
      W_funct_o      <= '0;
      W_valE_o       <= '0;
      W_valM_o       <= '0;
      W_rd_o         <= '0;
      W_default_pc_o <= '0;
      W_instr_o      <= '0;
      W_commit_o     <= 1'b0;
      W_pc_o         <= '0;
      W_pre_pc_o     <= '0;
      W_mem_err_o    <= 1'b0;
    end else if (!W_stall_i) begin
      W_opcode_o     <= M_opcode_i;
      W_funct_o      <= M_funct_i;
      W_valE_o       <= M_valE_i;
      W_valM_o       <= valm_nxt;
      W_rd_o         <= M_rd_i;
      W_default_pc_o <= M_default_pc_i;
      W_instr_o      <= M_instr_i;
      W_commit_o     <= M_commit_i;
      W_pc_o         <= M_pc_i;
      W_pre_pc_o     <= M_pre_pc_i;
      W_mem_err_o    <= err;
    end
  end

endmodule
